// File: rtl/ss_salida_pkg.sv
// rtl/ss_salida_pkg.sv - shared types and display constants for the ss_salida output subsystem
//
// Purpose: FSM state type, 7-segment patterns (active-low, gfedcba) and the
//          digit-to-segment helper used by the scan decoder.
// Ports:   none (package).

package ss_salida_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Number of double-dabble iterations for an 8-bit magnitude.
  localparam int BCD_ITERS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Entry n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Non-decimal nibbles cannot occur from the converter; show blank if they do.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_DIGITS[d];
  endfunction

endpackage

// File: rtl/ss_salida_if.sv
// rtl/ss_salida_if.sv - product handshake and display bus of ss_salida
//
// Purpose: groups the product valid/ready handshake with the display outputs.
// Signals: valid, Y[7:0]   product from the Booth core
//          ready           subsystem can accept a product
//          done            one-cycle pulse when display registers update
//          seg[6:0]        segments, active-low, seg[0]=a .. seg[6]=g
//          an[3:0]         digit enables, active-low, an[0]=units .. an[3]=sign
// Modports: master (product source / display sink), slave (ss_salida).

interface ss_salida_if;
  logic       valid;
  logic [7:0] Y;
  logic       ready;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output valid,
    output Y,
    input  ready,
    input  done,
    input  seg,
    input  an
  );

  modport slave (
    input  valid,
    input  Y,
    output ready,
    output done,
    output seg,
    output an
  );
endinterface

// File: rtl/ss_salida_bin_a_bcd.sv
// rtl/ss_salida_bin_a_bcd.sv - sequential double-dabble, 8-bit binary to 3 BCD digits
//
// Purpose: converts an 8-bit unsigned magnitude to hundreds/tens/units BCD,
//          one add-3/shift iteration per clock edge.
// Ports:   clk, rst     clock, asynchronous active-high reset
//          start        load mag and begin (ignored while busy)
//          mag[7:0]     value to convert
//          busy         iterations in progress
//          done         high during the cycle whose closing edge performs the
//                       final iteration, so the caller can latch bcd on that
//                       same edge
//          bcd[11:0]    result of the iteration about to be performed; equals
//                       the final conversion while done is high

module bin_a_bcd
  import ss_salida_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mag,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  // {bcd[11:0], mag[7:0]} working register
  logic [19:0] r_shift;
  logic [2:0]  r_iter;
  logic        r_busy;

  logic [11:0] w_adj;
  logic [19:0] w_step;

  always_comb begin
    w_adj = r_shift[19:8];
    for (int n = 0; n < 3; n++) begin
      if (r_shift[8 + 4*n +: 4] >= 4'd5) begin
        w_adj[4*n +: 4] = r_shift[8 + 4*n +: 4] + 4'd3;
      end
    end
    w_step = {w_adj[10:0], r_shift[7:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_shift <= w_step;
      r_iter  <= r_iter + 3'd1;
      if (r_iter == 3'(BCD_ITERS - 1)) begin
        r_busy <= 1'b0;
      end
    end else if (start) begin
      r_shift <= {12'd0, mag};
      r_iter  <= '0;
      r_busy  <= 1'b1;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_iter == 3'(BCD_ITERS - 1));
  assign bcd  = w_step[19:8];

endmodule

// File: rtl/ss_salida.sv
// rtl/ss_salida.sv - Booth product output stage: handshake, BCD conversion, 4-digit scan
//
// Purpose: accepts a signed 8-bit product, converts |Y| to BCD via bin_a_bcd,
//          holds sign + 3 digits in display registers and drives a
//          time-multiplexed common-anode 7-segment display.
// Params:  REFRESH_CYCLES  cycles each digit is held (>= 1)
// Ports:   clk          system clock, rising edge
//          rst          asynchronous reset, active-high
//          bus (slave)  valid/Y/ready handshake, done pulse, seg/an display

module ss_salida
  import ss_salida_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  ss_salida_if.slave  bus
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic        w_ready;
  logic        w_capture;
  logic [7:0]  w_mag;
  logic        r_sign_pend;

  logic        w_bcd_busy;
  logic        w_bcd_done;
  logic [11:0] w_bcd;

  logic        r_disp_sign;
  logic [3:0]  r_d2;
  logic [3:0]  r_d1;
  logic [3:0]  r_d0;
  logic        r_done;

  logic [CNT_W-1:0] r_refresh;
  logic [1:0]       r_idx;
  logic [6:0]       w_seg;

  // -128 negates to 8'h80, which read unsigned is the required 128.
  assign w_mag = bus.Y[7] ? (~bus.Y + 8'd1) : bus.Y;

  always_comb begin
    w_ready      = (r_state == ST_IDLE) && !w_bcd_busy;
    w_capture    = bus.valid && w_ready;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_capture)  w_state_next = ST_CONV;
      ST_CONV: if (w_bcd_done) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  bin_a_bcd u_bin_a_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_capture),
    .mag   (w_mag),
    .busy  (w_bcd_busy),
    .done  (w_bcd_done),
    .bcd   (w_bcd)
  );

  // Sign waits in r_sign_pend so the shown sign only changes with the digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_pend <= 1'b0;
      r_disp_sign <= 1'b0;
      r_d2        <= '0;
      r_d1        <= '0;
      r_d0        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_bcd_done;
      if (w_capture) begin
        r_sign_pend <= bus.Y[7];
      end
      if (w_bcd_done) begin
        r_disp_sign <= r_sign_pend;
        r_d2        <= w_bcd[11:8];
        r_d1        <= w_bcd[7:4];
        r_d0        <= w_bcd[3:0];
      end
    end
  end

  // Free-running scan, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == CNT_LAST) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + CNT_W'(1);
    end
  end

  // Leading-zero blanking: tens blank only when hundreds are blank too.
  always_comb begin
    w_seg = SEG_BLANK;
    case (r_idx)
      2'd0: w_seg = seg_of_digit(r_d0);
      2'd1: if (r_d2 != 4'd0 || r_d1 != 4'd0) w_seg = seg_of_digit(r_d1);
      2'd2: if (r_d2 != 4'd0) w_seg = seg_of_digit(r_d2);
      default: if (r_disp_sign) w_seg = SEG_MINUS;
    endcase
  end

  assign bus.ready = w_ready;
  assign bus.done  = r_done;
  assign bus.seg   = w_seg;
  assign bus.an    = ~(4'b0001 << r_idx);

endmodule

// File: tb/tb_ss_salida.sv
// tb/tb_ss_salida.sv - self-checking bench for ss_salida with REFRESH_CYCLES=4

module tb_ss_salida;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ss_salida_if bus();

  ss_salida #(.REFRESH_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: {digit3, digit2, digit1, digit0} for a product, from decimal arithmetic.
  function automatic logic [27:0] expect_disp(input logic [7:0] y);
    int v, m, h, t, u;
    logic [27:0] e;
    v = int'($signed(y));
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    e[27:21] = (v < 0) ? 7'b0111111 : 7'b1111111;
    e[20:14] = (h == 0) ? 7'b1111111 : pat(h);
    e[13:7]  = (h == 0 && t == 0) ? 7'b1111111 : pat(t);
    e[6:0]   = pat(u);
    return e;
  endfunction

  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Collects the seg value shown for each digit over a full scan (no checking).
  task automatic read_display(output logic [27:0] got, output bit ok);
    logic [3:0] seen;
    int k;
    seen = '0;
    got  = '1;
    ok   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = an_idx(bus.an);
      if (k < 0) ok = 1'b0;
      else begin
        got[7*k +: 7] = bus.seg;
        seen[k] = 1'b1;
      end
    end
    if (seen != 4'hF) ok = 1'b0;
  endtask

  // Sends one product; lat = edges from capture to done, ready_bad = cycles ready was high in CONV.
  task automatic send(input logic [7:0] y, output int lat, output int ready_bad);
    int w;
    @(negedge clk);
    w = 0;
    while (bus.ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.valid = 1'b1;
    bus.Y     = y;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.Y     = 8'($urandom);
    lat = -1;
    ready_bad = 0;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.ready !== 1'b0) ready_bad++;
    end
  endtask

  task automatic test_reset;
    logic [27:0] got, exp;
    bit ok;
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.Y = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b expected 1110", bus.an); end
    checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected 1000000", bus.seg); end
    @(posedge clk);
    #1 rst = 1'b0;
    read_display(got, ok);
    exp = expect_disp(8'h00);
    checks++; if (!ok) begin errors++; $display("FAIL reset_scan: an sequence incomplete or invalid"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[7*i +: 7] !== exp[7*i +: 7]) begin
        errors++; $display("FAIL reset_digit%0d: got %b expected %b", i, got[7*i +: 7], exp[7*i +: 7]);
      end
    end
  endtask

  task automatic test_product(input logic [7:0] y);
    logic [27:0] got, exp;
    bit ok;
    int lat, rb;
    send(y, lat, rb);
    checks++; if (lat !== 8) begin errors++; $display("FAIL latency Y=%h: got %0d expected 8", y, lat); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL ready_in_conv Y=%h: got %0d high cycles expected 0", y, rb); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width Y=%h: got %b expected 0", y, bus.done); end
    read_display(got, ok);
    exp = expect_disp(y);
    checks++; if (!ok) begin errors++; $display("FAIL scan Y=%h: an sequence incomplete or invalid", y); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[7*i +: 7] !== exp[7*i +: 7]) begin
        errors++; $display("FAIL display Y=%h digit%0d: got %b expected %b", y, i, got[7*i +: 7], exp[7*i +: 7]);
      end
    end
  endtask

  task automatic test_known;
    test_product(8'hE2);
    test_product(8'h80);
    test_product(8'h40);
    test_product(8'h00);
    test_product(8'h7F);
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) test_product(8'($urandom_range(0, 255)));
  endtask

  task automatic test_back_to_back;
    logic [27:0] e49, e30, got;
    bit ok;
    int n1, n2, rb, k, badseg;
    e49 = expect_disp(8'h31);
    e30 = expect_disp(8'hE2);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.Y = 8'h31;
    @(posedge clk);
    n1 = -1; rb = 0;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) bus.Y = 8'hE2;
      if (bus.done === 1'b1) begin n1 = n; break; end
      if (bus.ready !== 1'b0) rb++;
    end
    checks++; if (n1 !== 8) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", n1); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d high cycles expected 0", rb); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", bus.ready); end
    n2 = -1; badseg = 0;
    for (int m = 0; m <= 20; m++) begin
      k = an_idx(bus.an);
      if (k < 0 || bus.seg !== e49[7*k +: 7]) badseg++;
      @(negedge clk);
      if (m == 0) bus.valid = 1'b0;
      if (bus.done === 1'b1) begin n2 = m + 1; break; end
    end
    checks++; if (badseg !== 0) begin errors++; $display("FAIL b2b_hold_49: got %0d wrong cycles expected 0", badseg); end
    checks++; if (n2 !== 9) begin errors++; $display("FAIL b2b_period: got %0d expected 9", n2); end
    read_display(got, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_scan: an sequence incomplete or invalid"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[7*i +: 7] !== e30[7*i +: 7]) begin
        errors++; $display("FAIL b2b_display digit%0d: got %b expected %b", i, got[7*i +: 7], e30[7*i +: 7]);
      end
    end
  endtask

  task automatic test_scan;
    logic [3:0] hist [40];
    logic [3:0] exp_an;
    int i0, k0, step;
    bus.valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      hist[c] = bus.an;
    end
    i0 = -1;
    for (int c = 1; c < 8; c++) begin
      if (i0 < 0 && hist[c] !== hist[c-1]) i0 = c;
    end
    checks++; if (i0 < 0) begin errors++; $display("FAIL scan_transition: got none expected one within 8 cycles"); end
    else begin
      k0 = an_idx(hist[i0]);
      for (int c = i0; c < i0 + 32; c++) begin
        step   = (c - i0) / 4;
        exp_an = 4'b1111 ^ (4'b0001 << ((k0 + step) % 4));
        checks++;
        if (hist[c] !== exp_an) begin
          errors++; $display("FAIL scan_an cycle%0d: got %b expected %b", c, hist[c], exp_an);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv;
    logic [27:0] got, exp;
    bit ok;
    int dones;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.Y = 8'h31;
    @(posedge clk);
    #1 bus.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000) begin
      errors++; $display("FAIL midreset_outputs: got an=%b seg=%b expected an=1110 seg=1000000", bus.an, bus.seg);
    end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", bus.ready); end
    dones = (bus.done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
    read_display(got, ok);
    exp = expect_disp(8'h00);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_scan: an sequence incomplete or invalid"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[7*i +: 7] !== exp[7*i +: 7]) begin
        errors++; $display("FAIL midreset_digit%0d: got %b expected %b", i, got[7*i +: 7], exp[7*i +: 7]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.Y = 8'h00;
    test_reset;
    test_known;
    test_random;
    test_back_to_back;
    test_scan;
    test_reset_mid_conv;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_salida.md
# ss_salida

Output subsystem of the 4-bit Booth multiplier, at the opposite end of the datapath from `ss_entrada`. It accepts the signed 8-bit product from the Booth core through a valid/ready handshake and converts it to sign plus three BCD digits with a sequential double-dabble. It then drives a 4-digit, time-multiplexed, common-anode 7-segment display.

## Interface
- `REFRESH_CYCLES`, default 50000: clock cycles each digit is held before the scan advances (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `valid`  in  1  product on `Y` is valid.
- `Y`  in  8  signed two's-complement product.
- `ready`  out  1  block can accept a product.
- `done`  out  1  one-cycle pulse when the display registers update.
- `seg`  out  7  segments, active-low, `seg[0]`=a … `seg[6]`=g.
- `an`  out  4  digit enables, active-low, `an[0]`=units … `an[3]`=sign.

## Operation
- Capture: `valid && ready` at a rising edge latches `sign=Y[7]` and `mag=|Y|` (8-bit unsigned, −128→128). The FSM enters CONV.
- FSM states:
  - IDLE: `ready=1`; leaves on capture.
  - CONV: `ready=0`; performs 8 iterations, one per edge. Each iteration adds 3 to any BCD nibble ≥5, then shifts `{bcd[11:0],mag}` left by 1.
  - The 8th iteration loads the display registers (`disp_sign`, `d2`, `d1`, `d0`), sets `done`, and returns to IDLE.
- `valid` while not ready is ignored, not queued. `Y` is sampled only on the capture edge.
- Display registers hold the previous result throughout CONV.
- Digit content:
  - digit3 shows `-` if `disp_sign`, otherwise blank.
  - digit2 shows hundreds, or blank if zero.
  - digit1 shows tens, or blank if hundreds and tens are both zero.
  - digit0 always shows units.
- Patterns (active-low, gfedcba):
  - digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus: 0111111
  - blank: 1111111
- Scan:
  - Refresh counter runs 0..`REFRESH_CYCLES`−1 and wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - `an = ~(4'b1 << idx)`. `seg` is decoded from `idx` and the display registers.
  - The scan is independent of the FSM and never stalls.
- Reset (any time, including mid-CONV) aborts the conversion and forces:
  - FSM to IDLE, `ready=1`, `done=0`
  - display registers to zero, sign clear
  - `idx=0`, counter=0
  - outputs `an=1110`, `seg=1000000` (display shows "0")

## Timing
- Capture at edge k. Iterations at edges k+1..k+8.
- `done=1` and new `seg` content are visible in the cycle after edge k+8. `done` is exactly one cycle wide.
- `ready` is low after edge k and high again after edge k+8.
- A `valid` present in the `done` cycle is accepted, giving back-to-back throughput of 9 cycles per product.
- `seg` and `an` depend only on registers, with no combinational path from `valid`/`Y`.
- Each digit is held exactly `REFRESH_CYCLES` cycles. A full scan takes 4×`REFRESH_CYCLES`.

## Structure
- Package `ss_salida_pkg` contains:
  - FSM state enum (IDLE, CONV)
  - `SEG_BLANK`, `SEG_MINUS`
  - 10-entry digit-pattern constant array
- Sub-module `bin_a_bcd`: sequential double-dabble.
  - Inputs: `start`, `mag[7:0]`.
  - Outputs: `busy`, `done`, `bcd[11:0]`.
  - `ss_salida` keeps the handshake, display registers and scan/decoder.

## Test plan
- Reset: hold `rst=1` → `ready=1`, `done=0`, `an=1110`, `seg=1000000`. After release with no `valid`, `seg` blank on digits 1–3.
- `Y=8'hE2` (−30 = −5×6) pulsed one cycle → `done` 8 cycles after capture. Scanning gives digit3=0111111, digit2=1111111, digit1=0110000, digit0=1000000.
- `Y=8'h80` → `-`,`1`,`2`,`8` (1111001, 0100100, 0000000).
  - `Y=8'h40` → blank, blank, `6`, `4`.
  - `Y=8'h00` → only digit0 `0`.
- Hold `valid=1` while changing `Y` from `8'h31` to `8'hE2` during CONV → `ready=0` for 8 cycles. The display shows 49, then `8'hE2` is captured in the `done` cycle and the display shows −30.
- `REFRESH_CYCLES=4` → `an` steps 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.
- Assert `rst` 4 cycles into CONV of `8'h31` → no `done` pulse, display returns to "0", `ready=1` in the first cycle after release.
